// File: rtl/puertas_actuador.sv
// Elevator door mechanism model: turns door commands and the obstruction
// sensor into door status, door position and an open-dwell timeout flag.
module puertas_actuador #(
    parameter int T_VIAJE   = 4,
    parameter int T_ABIERTA = 8,
    parameter int W         = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   salida_puertas,
    input  logic         sensor,
    output logic [1:0]   puertas,
    output logic         timeout,
    output logic [W-1:0] posicion
);

    // Door states; the encoding is also the external status code.
    localparam logic [1:0] CERRADAS  = 2'b00;
    localparam logic [1:0] ABIERTAS  = 2'b01;
    localparam logic [1:0] CERRANDO  = 2'b10;
    localparam logic [1:0] ABRIENDO  = 2'b11;

    // Command codes; 11 matches neither and so acts as "nada".
    localparam logic [1:0] CMD_ABRIR  = 2'b01;
    localparam logic [1:0] CMD_CERRAR = 2'b10;

    localparam logic [W-1:0] POS_ABIERTA = W'(T_VIAJE);
    localparam logic [W-1:0] POS_PREVIA  = W'(T_VIAJE - 1);
    localparam logic [W-1:0] TMR_MAX     = W'(T_ABIERTA);
    localparam logic [W-1:0] ONE         = W'(1);
    localparam logic [W-1:0] ZERO        = '0;

    logic [1:0]   state;
    logic [W-1:0] timer;

    // Door state, position and dwell timer advance together on each edge.
    always_ff @(posedge clk) begin
        // NOTE: a synchronous reset clears every register in this block;
        // all state updates use non-blocking assignments so the new values
        // are computed from the old ones consistently.
        if (reset) begin
            state    <= CERRADAS;
            posicion <= ZERO;
            timer    <= ZERO;
        end else begin
            case (state)
                CERRADAS: begin
                    if (salida_puertas == CMD_ABRIR)
                        state <= ABRIENDO;
                end

                ABRIENDO: begin
                    if (salida_puertas == CMD_CERRAR) begin
                        state <= CERRANDO;
                    end else if (posicion >= POS_PREVIA) begin
                        // Last step of travel (clamped so a reversal taken
                        // right at the open end cannot overshoot).
                        posicion <= POS_ABIERTA;
                        state    <= ABIERTAS;
                        timer    <= ZERO;
                    end else begin
                        posicion <= posicion + ONE;
                    end
                end

                ABIERTAS: begin
                    if (salida_puertas == CMD_CERRAR) begin
                        state <= CERRANDO;
                        timer <= ZERO;
                    end else if (salida_puertas == CMD_ABRIR || sensor) begin
                        timer <= ZERO;
                    end else if (timer != TMR_MAX) begin
                        timer <= timer + ONE;
                    end
                end

                CERRANDO: begin
                    if (salida_puertas == CMD_ABRIR) begin
                        state <= ABRIENDO;
                    end else if (sensor) begin
                        // Obstruction: freeze the doors where they are.
                        state <= CERRANDO;
                    end else if (posicion <= ONE) begin
                        // Last step of travel (clamped so a reversal taken
                        // right at the closed end cannot wrap).
                        posicion <= ZERO;
                        state    <= CERRADAS;
                    end else begin
                        posicion <= posicion - ONE;
                    end
                end

                default: state <= CERRADAS;
            endcase
        end
    end

    // Status is the state register itself; timeout decodes registered state.
    always_comb begin
        puertas = state;
        timeout = (state == ABIERTAS) && (timer == TMR_MAX);
    end

endmodule

// File: tb/tb_puertas_actuador.sv
// Self-checking bench for puertas_actuador: directed scenarios followed by
// random commands, all compared against a behavioural door model.
module tb_puertas_actuador;

    localparam int T_VIAJE   = 4;
    localparam int T_ABIERTA = 8;
    localparam int W         = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   salida_puertas = 2'b00;
    logic         sensor = 1'b0;
    logic [1:0]   puertas;
    logic         timeout;
    logic [W-1:0] posicion;

    int checks = 0;
    int errors = 0;

    puertas_actuador #(.T_VIAJE(T_VIAJE), .T_ABIERTA(T_ABIERTA), .W(W)) dut (
        .clk(clk),
        .reset(reset),
        .salida_puertas(salida_puertas),
        .sensor(sensor),
        .puertas(puertas),
        .timeout(timeout),
        .posicion(posicion)
    );

    always #5 clk = ~clk;

    // Behavioural model: door phase, integer position and dwell count.
    typedef enum {M_CLOSED, M_OPENING, M_OPEN, M_CLOSING} phase_t;
    phase_t m_phase = M_CLOSED;
    int     m_pos   = 0;
    int     m_dwell = 0;

    function automatic logic [1:0] status_code(phase_t p);
        case (p)
            M_CLOSED:  return 2'b00;
            M_OPEN:    return 2'b01;
            M_CLOSING: return 2'b10;
            default:   return 2'b11;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic [1:0] cmd, input logic sens);
        bit abrir, cerrar;
        abrir  = (cmd == 2'b01);
        cerrar = (cmd == 2'b10);
        if (rst) begin
            m_phase = M_CLOSED;
            m_pos   = 0;
            m_dwell = 0;
        end else begin
            case (m_phase)
                M_CLOSED: if (abrir) m_phase = M_OPENING;
                M_OPENING: begin
                    if (cerrar) m_phase = M_CLOSING;
                    else begin
                        m_pos = (m_pos + 1 > T_VIAJE) ? T_VIAJE : m_pos + 1;
                        if (m_pos == T_VIAJE) begin
                            m_phase = M_OPEN;
                            m_dwell = 0;
                        end
                    end
                end
                M_OPEN: begin
                    if (cerrar) begin
                        m_phase = M_CLOSING;
                        m_dwell = 0;
                    end else if (abrir || sens) m_dwell = 0;
                    else m_dwell = (m_dwell + 1 > T_ABIERTA) ? T_ABIERTA : m_dwell + 1;
                end
                M_CLOSING: begin
                    if (abrir) m_phase = M_OPENING;
                    else if (!sens) begin
                        m_pos = (m_pos - 1 < 0) ? 0 : m_pos - 1;
                        if (m_pos == 0) m_phase = M_CLOSED;
                    end
                end
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge with the given inputs, then compare all outputs.
    task automatic step(input logic rst, input logic [1:0] cmd, input logic sens);
        reset          = rst;
        salida_puertas = cmd;
        sensor         = sens;
        @(posedge clk);
        model_edge(rst, cmd, sens);
        #1;
        check("puertas", {6'd0, puertas}, {6'd0, status_code(m_phase)});
        check("posicion", 8'(posicion), 8'(m_pos));
        check("timeout", {7'd0, timeout},
              {7'd0, (m_phase == M_OPEN && m_dwell == T_ABIERTA) ? 1'b1 : 1'b0});
    endtask

    initial begin
        // Reset state
        step(1'b1, 2'b00, 1'b0);
        check("reset_puertas", {6'd0, puertas}, 8'd0);
        check("reset_pos", 8'(posicion), 8'd0);

        // Full open: 4 cycles of 11 with position 0..3, then open at 4
        for (int i = 0; i < T_VIAJE; i++) begin
            step(1'b0, 2'b01, 1'b0);
            check("open_travel", {6'd0, puertas}, 8'd3);
            check("open_pos", 8'(posicion), 8'(i));
        end
        step(1'b0, 2'b01, 1'b0);
        check("open_done", {6'd0, puertas}, 8'd1);
        check("open_pos_full", 8'(posicion), 8'd4);

        // Timeout exactly T_ABIERTA cycles after reaching open
        for (int i = 1; i <= T_ABIERTA; i++) begin
            step(1'b0, 2'b00, 1'b0);
            check("dwell_timeout", {7'd0, timeout}, (i == T_ABIERTA) ? 8'd1 : 8'd0);
        end
        step(1'b0, 2'b00, 1'b0);
        check("timeout_held", {7'd0, timeout}, 8'd1);

        // Close fully
        step(1'b0, 2'b10, 1'b0);
        check("close_start", {6'd0, puertas}, 8'd2);
        check("close_timeout", {7'd0, timeout}, 8'd0);
        for (int i = 0; i < T_VIAJE; i++) step(1'b0, 2'b00, 1'b0);
        check("closed", {6'd0, puertas}, 8'd0);

        // Reversal at position 2
        repeat (T_VIAJE + 1) step(1'b0, 2'b01, 1'b0);
        step(1'b0, 2'b10, 1'b0);
        repeat (2) step(1'b0, 2'b00, 1'b0);
        check("rev_pos", 8'(posicion), 8'd2);
        step(1'b0, 2'b01, 1'b0);
        check("rev_state", {6'd0, puertas}, 8'd3);
        check("rev_pos_hold", 8'(posicion), 8'd2);
        repeat (2) step(1'b0, 2'b00, 1'b0);
        check("rev_open", {6'd0, puertas}, 8'd1);

        // Obstruction while closing at position 3
        step(1'b0, 2'b10, 1'b0);
        step(1'b0, 2'b00, 1'b0);
        repeat (5) begin
            step(1'b0, 2'b00, 1'b1);
            check("obst_pos", 8'(posicion), 8'd3);
            check("obst_state", {6'd0, puertas}, 8'd2);
        end
        repeat (3) step(1'b0, 2'b00, 1'b0);
        check("obst_closed", {6'd0, puertas}, 8'd0);

        // Sensor while open at dwell 6 restarts the full dwell
        repeat (T_VIAJE + 1) step(1'b0, 2'b01, 1'b0);
        repeat (6) step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b1);
        for (int i = 1; i <= T_ABIERTA; i++) begin
            step(1'b0, 2'b00, 1'b0);
            check("sens_dwell", {7'd0, timeout}, (i == T_ABIERTA) ? 8'd1 : 8'd0);
        end

        // Reset mid-travel while opening at position 2
        step(1'b0, 2'b10, 1'b0);
        repeat (T_VIAJE) step(1'b0, 2'b00, 1'b0);
        repeat (3) step(1'b0, 2'b01, 1'b0);
        check("pre_reset_pos", 8'(posicion), 8'd2);
        step(1'b1, 2'b01, 1'b0);
        check("midreset_state", {6'd0, puertas}, 8'd0);
        check("midreset_pos", 8'(posicion), 8'd0);

        // Illegal command 11 while closed
        repeat (3) begin
            step(1'b0, 2'b11, 1'b0);
            check("illegal_cmd", {6'd0, puertas}, 8'd0);
        end

        // Random commands, sensor and occasional reset
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
